// File: rtl/sr_rw_ctrl.sv
// sr_rw_ctrl: sequencer for a WIDTH-bit chip configuration shift register.
// A start request serialises the latched config word onto sin (MSB first)
// with a generated clk_sr, captures the chip's previous contents from sout
// into dout, then pulses load_sr so the chip latches the new word.
//
// Optional build macro: SR_READBACK_CMP_EN
//   When defined, the word written by the previous completed sequence is
//   kept and compared against the word read back by the current one; the
//   result appears on match. Otherwise match is tied to 0.
module sr_rw_ctrl #(
    parameter int WIDTH     = 170,
    parameter int CNT_WIDTH = 8,
    parameter int DIV       = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    input  logic             sout,
    output logic             clk_sr,
    output logic             sin,
    output logic             load_sr,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout,
    output logic             match
);

    // Handshake: start is a request that is honoured only while busy is low
    // (state IDLE); requests seen while busy is high are dropped, not queued.
    // busy stays high from LOAD through DONE, and done pulses for exactly one
    // cycle in DONE, at which point dout holds the complete readback word.

    localparam int                   DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [CNT_WIDTH-1:0] BIT_LAST = CNT_WIDTH'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SHIFT = 3'd2,
        LATCH = 3'd3,
        DONE  = 3'd4
    } state_e;

    // FSM state is kept as a named enum so checkers can bind to dut.state.
    state_e               state;
    logic [WIDTH-1:0]     shadow;
    logic [CNT_WIDTH-1:0] bit_cnt;
    logic [DIV_W-1:0]     div_cnt;

    // Main sequencer: all chip-facing outputs are registered so clk_sr and
    // load_sr are glitch-free. clk_sr doubles as the low/high phase flag.
    // shadow is rotated (not shifted) once per bit, so after WIDTH bits it
    // holds the original word again for the readback comparison.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            shadow  <= '0;
            bit_cnt <= '0;
            div_cnt <= '0;
            clk_sr  <= 1'b0;
            sin     <= 1'b0;
            load_sr <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            dout    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    clk_sr  <= 1'b0;
                    load_sr <= 1'b0;
                    if (start) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                    end
                end

                LOAD: begin
                    shadow  <= din;
                    sin     <= din[WIDTH-1];
                    bit_cnt <= '0;
                    div_cnt <= '0;
                    clk_sr  <= 1'b0;
                    state   <= SHIFT;
                end

                SHIFT: begin
                    if (div_cnt != DIV_LAST) begin
                        div_cnt <= div_cnt + 1'b1;
                    end else begin
                        div_cnt <= '0;
                        if (!clk_sr) begin
                            // End of low phase: raise clk_sr and sample the chip.
                            clk_sr <= 1'b1;
                            dout   <= {dout[WIDTH-2:0], sout};
                        end else begin
                            // End of high phase: bit complete.
                            clk_sr <= 1'b0;
                            shadow <= {shadow[WIDTH-2:0], shadow[WIDTH-1]};
                            if (bit_cnt == BIT_LAST) begin
                                load_sr <= 1'b1;
                                state   <= LATCH;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                                sin     <= shadow[WIDTH-2];
                            end
                        end
                    end
                end

                LATCH: begin
                    clk_sr <= 1'b0;
                    if (div_cnt != DIV_LAST) begin
                        div_cnt <= div_cnt + 1'b1;
                    end else begin
                        div_cnt <= '0;
                        load_sr <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end

                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    clk_sr  <= 1'b0;
                    load_sr <= 1'b0;
                end
            endcase
        end
    end

`ifdef SR_READBACK_CMP_EN
    logic [WIDTH-1:0] last_wr;

    // Readback check: the chip should return what we wrote last time.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_wr <= '0;
            match   <= 1'b0;
        end else if (state == DONE) begin
            match   <= (dout == last_wr);
            last_wr <= shadow;
        end
    end
`else
    assign match = 1'b0;
`endif

endmodule

// File: tb/tb_sr_rw_ctrl.sv
// tb_sr_rw_ctrl: randomized self-checking bench for sr_rw_ctrl.
// Two instances: the default build (WIDTH=170, DIV=2) and a small one
// (WIDTH=8, DIV=1). Each drives a behavioural chip model (a plain shift
// register clocked by clk_sr) so readback can be predicted as "the word
// written by the previous completed sequence".
module tb_sr_rw_ctrl;

  localparam int MW = 170;
  localparam int MD = 2;
  localparam int SW = 8;
  localparam int SD = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic          m_start, m_sout, m_clk_sr, m_sin, m_load_sr, m_busy, m_done, m_match;
  logic [MW-1:0] m_din, m_dout;
  logic          s_start, s_sout, s_clk_sr, s_sin, s_load_sr, s_busy, s_done, s_match;
  logic [SW-1:0] s_din, s_dout;

  sr_rw_ctrl #(.WIDTH(MW), .CNT_WIDTH(8), .DIV(MD)) dut (
    .clk(clk), .rst(rst), .start(m_start), .din(m_din), .sout(m_sout),
    .clk_sr(m_clk_sr), .sin(m_sin), .load_sr(m_load_sr), .busy(m_busy),
    .done(m_done), .dout(m_dout), .match(m_match)
  );

  sr_rw_ctrl #(.WIDTH(SW), .CNT_WIDTH(3), .DIV(SD)) dut_s (
    .clk(clk), .rst(rst), .start(s_start), .din(s_din), .sout(s_sout),
    .clk_sr(s_clk_sr), .sin(s_sin), .load_sr(s_load_sr), .busy(s_busy),
    .done(s_done), .dout(s_dout), .match(s_match)
  );

  // ---------------- chip models ----------------
  logic          loop_en;
  logic [MW-1:0] m_chip;
  logic [SW-1:0] s_chip;

  always @(posedge m_clk_sr or negedge rst)
    if (!rst) m_chip <= '0;
    else      m_chip <= {m_chip[MW-2:0], m_sin};

  always @(posedge s_clk_sr or negedge rst)
    if (!rst) s_chip <= '0;
    else      s_chip <= {s_chip[SW-2:0], s_sin};

  assign m_sout = loop_en ? m_chip[MW-1] : 1'b0;
  assign s_sout = loop_en ? s_chip[SW-1] : 1'b0;

  // Observation mux so one sequence checker serves both instances.
  logic         sel;
  logic         o_clk_sr, o_sin, o_load_sr, o_busy, o_done, o_match;
  logic [255:0] o_dout;
  assign o_clk_sr  = sel ? s_clk_sr  : m_clk_sr;
  assign o_sin     = sel ? s_sin     : m_sin;
  assign o_load_sr = sel ? s_load_sr : m_load_sr;
  assign o_busy    = sel ? s_busy    : m_busy;
  assign o_done    = sel ? s_done    : m_done;
  assign o_match   = sel ? s_match   : m_match;
  assign o_dout    = sel ? {{(256-SW){1'b0}}, s_dout} : {{(256-MW){1'b0}}, m_dout};

  // ---------------- reference model state ----------------
  logic [255:0] m_prev, s_prev;   // what each chip currently holds
  logic [255:0] m_last, s_last;   // last word the DUT completed writing

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [255:0] exp_q[$];

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_start(input bit which, input logic val);
    if (which) s_start = val;
    else       m_start = val;
  endtask

  task automatic drive_din(input bit which, input logic [255:0] val);
    if (which) s_din = val[SW-1:0];
    else       m_din = val[MW-1:0];
  endtask

  function automatic logic [255:0] rand_word();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // One full write sequence, observed cycle by cycle on the falling edge.
  // k counts rising edges since the edge that sampled start (edge N -> k=0).
  task automatic run_seq(input bit which, input logic [255:0] word_in, input bit loop_i,
                         input bit inject);
    int w, d, exp_done_k, rises, done_k, done_cnt, busy_cnt, busy_segs;
    int load_cnt, hi_run, bad_hi, bad_clk;
    logic [255:0] word, mask, exp_dout, sin_word, got_bit, exp_bit;
    logic prev_clk, prev_busy, exp_match;
    w          = which ? SW : MW;
    d          = which ? SD : MD;
    exp_done_k = 1 + 2 * d * w + d;
    mask       = (256'd1 << w) - 256'd1;
    word       = word_in & mask;
    sel        = which;
    loop_en    = loop_i;
    exp_dout   = loop_i ? (which ? s_prev : m_prev) : '0;
`ifdef SR_READBACK_CMP_EN
    exp_match  = (exp_dout == (which ? s_last : m_last));
`else
    exp_match  = 1'b0;
`endif
    exp_q.delete();
    for (int i = w - 1; i >= 0; i--) exp_q.push_back({255'd0, word[i]});

    rises = 0; done_k = -1; done_cnt = 0; busy_cnt = 0; busy_segs = 0;
    load_cnt = 0; hi_run = 0; bad_hi = 0; bad_clk = 0;
    sin_word = '0; prev_clk = 1'b0; prev_busy = 1'b0;

    @(negedge clk);
    drive_din(which, word);
    drive_start(which, 1'b1);
    for (int k = 0; k < exp_done_k + 4; k++) begin
      @(negedge clk);
      if (k == 1) drive_din(which, ~word);   // must not affect the sequence
      drive_start(which, inject && (k == 10 || k == 300));
      if (o_clk_sr && !prev_clk) begin
        rises++;
        sin_word = {sin_word[254:0], o_sin};
        if (exp_q.size() > 0) begin
          exp_bit = exp_q.pop_front();
          got_bit = {255'd0, o_sin};
          if (got_bit !== exp_bit) bad_hi++;
        end
      end
      if (o_clk_sr) hi_run++;
      if (!o_clk_sr && prev_clk) begin
        if (hi_run != d) bad_hi++;
        hi_run = 0;
      end
      if (o_clk_sr && (!o_busy || o_load_sr)) bad_clk++;
      if (o_load_sr) load_cnt++;
      if (o_done) begin done_cnt++; done_k = k; end
      if (o_busy) busy_cnt++;
      if (o_busy && !prev_busy) busy_segs++;
      prev_clk  = o_clk_sr;
      prev_busy = o_busy;
    end
    drive_start(which, 1'b0);

    check_val("sin_word",  sin_word & mask, word);
    check_val("clk_rises", 256'(rises), 256'(w));
    check_val("clk_shape", 256'(bad_hi), 256'd0);
    check_val("clk_idle",  256'(bad_clk), 256'd0);
    check_val("load_len",  256'(load_cnt), 256'(d));
    check_val("done_cnt",  256'(done_cnt), 256'd1);
    check_val("done_k",    256'(done_k), 256'(exp_done_k));
    check_val("busy_len",  256'(busy_cnt), 256'(exp_done_k + 1));
    check_val("busy_segs", 256'(busy_segs), 256'd1);
    check_val("dout",      o_dout, exp_dout);
    check_val("match",     {255'd0, o_match}, {255'd0, exp_match});

    if (which) begin s_prev = word; s_last = word; end
    else       begin m_prev = word; m_last = word; end
  endtask

  // start held high: back-to-back sequences with one IDLE cycle in between.
  task automatic run_hold(input logic [255:0] word_in);
    int d1, d2, n_done, n_idle, waited;
    logic [255:0] word;
    logic exp_match;
    word = word_in & ((256'd1 << MW) - 256'd1);
    sel = 1'b0; loop_en = 1'b1;
    d1 = -1; d2 = -1; n_done = 0; n_idle = 0;
    @(negedge clk);
    m_din   = word[MW-1:0];
    m_start = 1'b1;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (m_done) begin
        n_done++;
        if (d1 < 0) d1 = k; else if (d2 < 0) d2 = k;
      end
      if (!m_busy) n_idle++;
    end
    m_start = 1'b0;
    waited = 0;
    while (m_busy && waited < 1000) begin @(negedge clk); waited++; end
    check_val("hold_timeout", {255'd0, m_busy}, 256'd0);
    check_val("hold_done_n",  256'(n_done), 256'd2);
    check_val("hold_d1",      256'(d1), 256'd683);
    check_val("hold_gap",     256'(d2 - d1), 256'd685);
    check_val("hold_idle",    256'(n_idle), 256'd2);
    check_val("hold_dout",    {{(256-MW){1'b0}}, m_dout}, word);
    // Three sequences of the same word ran; the last one reads back that word.
`ifdef SR_READBACK_CMP_EN
    exp_match = 1'b1;
`else
    exp_match = 1'b0;
`endif
    check_val("hold_match", {255'd0, m_match}, {255'd0, exp_match});
    m_prev = word; m_last = word;
  endtask

  // Asynchronous reset in the middle of SHIFT aborts cleanly.
  task automatic run_reset_mid(input logic [255:0] word_in);
    int rises, guard, n_done, n_busy;
    logic prev_clk;
    sel = 1'b0; loop_en = 1'b1;
    @(negedge clk);
    m_din = word_in[MW-1:0];
    m_start = 1'b1;
    @(negedge clk);
    m_start = 1'b0;
    rises = 0; guard = 0; prev_clk = 1'b0;
    while (rises < 50 && guard < 1000) begin
      @(negedge clk);
      if (m_clk_sr && !prev_clk) rises++;
      prev_clk = m_clk_sr;
      guard++;
    end
    check_val("rst_reach_bit50", 256'(rises), 256'd50);
    #2 rst = 1'b0;
    #1 check_val("rst_async_outs", {251'd0, m_clk_sr, m_sin, m_load_sr, m_busy, m_done}, 256'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    n_done = 0; n_busy = 0;
    for (int k = 0; k < 800; k++) begin
      @(negedge clk);
      if (m_done) n_done++;
      if (m_busy) n_busy++;
    end
    check_val("rst_no_done", 256'(n_done), 256'd0);
    check_val("rst_idle",    256'(n_busy), 256'd0);
    m_prev = '0; m_last = '0; s_prev = '0; s_last = '0;
  endtask

  // ---------------- main stimulus ----------------
  logic [255:0] word_a, word_b, alt10;

  initial begin
    rst = 1'b0; m_start = 1'b0; s_start = 1'b0; m_din = '0; s_din = '0;
    loop_en = 1'b0; sel = 1'b0;
    m_prev = '0; m_last = '0; s_prev = '0; s_last = '0;
    repeat (3) @(negedge clk);
    check_val("reset_outs", {246'd0, m_clk_sr, m_sin, m_load_sr, m_busy, m_done, m_match,
                             s_clk_sr, s_sin, s_load_sr, s_busy}, 256'd0);
    check_val("reset_dout", {{(256-MW){1'b0}}, m_dout}, 256'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // 1010... with sout tied low, plus starts injected while busy.
    alt10 = '0;
    for (int i = 0; i < MW; i++) alt10[i] = (i % 2 == 1);
    run_seq(1'b0, alt10, 1'b0, 1'b1);

    // Loopback: write A then B; B's readback must be A.
    word_a = '0;
    for (int i = 0; i < MW; i++) word_a[i] = (i % 2 == 0);
    word_b = (256'd1 << MW) - 256'd1;
    run_seq(1'b0, word_a, 1'b1, 1'b0);
    run_seq(1'b0, word_b, 1'b1, 1'b0);

    // Small instance: C3 then random words.
    run_seq(1'b1, 256'hC3, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) run_seq(1'b1, rand_word(), 1'b1, 1'b0);

    // Random words on the default instance with random idle gaps.
    for (int i = 0; i < 3; i++) begin
      repeat ($urandom_range(0, 7)) @(negedge clk);
      run_seq(1'b0, rand_word(), 1'b1, 1'b0);
    end

    run_hold(rand_word());
    run_reset_mid(rand_word());
    run_seq(1'b0, rand_word(), 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time bound.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
